// File: rtl/xbar_slave_arbiter_if.sv
// Request/grant bundle between the masters of one crossbar slave port and its arbiter.
// The slave modport is the arbiter side; the master modport is the requesting/slave-response side.
interface xbar_slave_arbiter_if #(
    parameter int MASTERS = 4
);
    localparam int IDX_W = $clog2(MASTERS);

    logic [MASTERS-1:0] req;
    logic [MASTERS-1:0] cmd;
    logic               sack;
    logic               sresp;
    logic [MASTERS-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  req, cmd, sack, sresp,
        output gnt, gnt_idx, busy, timeout_err
    );

    modport master (
        output req, cmd, sack, sresp,
        input  gnt, gnt_idx, busy, timeout_err
    );
endinterface

// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter owning one crossbar slave port; grants one master per read/write transaction.
// Latency: grant registered 1 cycle after req is sampled in IDLE; at least one idle cycle between grants.
// Backpressure: owner holds the port until sack (write) or sresp (read); XBAR_ARB_TIMEOUT_EN adds a watchdog.
module xbar_slave_arbiter #(
    parameter int MASTERS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    xbar_slave_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(MASTERS);

    if (MASTERS < 2 || MASTERS > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("xbar_slave_arbiter: MASTERS or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_winner;
    logic               cmd_wr;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [IDX_W:0]     cand;
    logic               done;
    logic               to_resp;
    logic               wd_expire;

    // First requester strictly after last_winner, wrapping modulo MASTERS.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= MASTERS; i++) begin
            cand = {1'b0, last_winner} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(MASTERS)) begin
                cand = cand - (IDX_W+1)'(MASTERS);
            end
            if (!any_req && bus.req[cand[IDX_W-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        done    = ((state == WAIT_ACK) && bus.sack && (cmd_wr || bus.sresp)) ||
                  ((state == WAIT_RESP) && bus.sresp);
        to_resp = (state == WAIT_ACK) && bus.sack && !cmd_wr && !bus.sresp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.gnt     <= '0;
            bus.gnt_idx <= '0;
            bus.busy    <= 1'b0;
            cmd_wr      <= 1'b0;
            last_winner <= IDX_W'(MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= WAIT_ACK;
                        bus.gnt     <= MASTERS'(1) << winner;
                        bus.gnt_idx <= winner;
                        bus.busy    <= 1'b1;
                        cmd_wr      <= bus.cmd[winner];
                    end
                end
                WAIT_ACK, WAIT_RESP: begin
                    // Completion and watchdog expiry both release the port and advance the pointer.
                    if (done || wd_expire) begin
                        state       <= IDLE;
                        bus.gnt     <= '0;
                        bus.gnt_idx <= '0;
                        bus.busy    <= 1'b0;
                        last_winner <= bus.gnt_idx;
                    end else if (to_resp) begin
                        state <= WAIT_RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XBAR_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        timeout_q;

    // Expiry lands on the edge closing the TIMEOUT-th waiting cycle, unless sack/sresp arrives in it.
    always_comb begin
        wd_expire = (((state == WAIT_ACK) && !bus.sack) || ((state == WAIT_RESP) && !bus.sresp)) &&
                    (wd_cnt == 16'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_expire;
            if (state == IDLE || to_resp) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign wd_expire       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter (MASTERS=4, TIMEOUT=8): directed scenarios plus random traffic vs a transaction-level model.
module tb_xbar_slave_arbiter;
    localparam int M  = 4;
    localparam int TO = 8;

    logic clk;
    logic rst;

    xbar_slave_arbiter_if #(.MASTERS(M)) bus ();

    xbar_slave_arbiter #(.MASTERS(M), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Transaction-level reference: who owns the port and what it still waits for.
    bit m_active;
    int m_owner;
    bit m_is_wr;
    bit m_acked;
    int m_age;
    int m_ptr;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit found;
        bit done;
        bit adv;
        int m;
        m_to = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = M - 1;
        end else if (!m_active) begin
            found = 1'b0;
            for (int k = 1; k <= M; k++) begin
                m = (m_ptr + k) % M;
                if (!found && bus.req[m]) begin
                    found    = 1'b1;
                    m_active = 1'b1;
                    m_owner  = m;
                    m_is_wr  = bus.cmd[m];
                    m_acked  = 1'b0;
                    m_age    = 0;
                end
            end
        end else begin
            done = 1'b0;
            adv  = 1'b0;
            if (!m_acked) begin
                if (bus.sack) begin
                    if (m_is_wr || bus.sresp) done = 1'b1;
                    else begin
                        m_acked = 1'b1;
                        m_age   = 0;
                        adv     = 1'b1;
                    end
                end
            end else if (bus.sresp) begin
                done = 1'b1;
            end
            if (done) begin
                m_active = 1'b0;
                m_ptr    = m_owner;
            end
`ifdef XBAR_ARB_TIMEOUT_EN
            else if (!adv) begin
                m_age++;
                if (m_age == TO) begin
                    m_active = 1'b0;
                    m_ptr    = m_owner;
                    m_to     = 1'b1;
                end
            end
`endif
        end
    endtask

    // One cycle: check this cycle's outputs at negedge, advance the model on posedge, drop pulses.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("gnt", bus.gnt, m_active ? (32'd1 << m_owner) : 32'd0);
            check("busy", bus.busy, m_active);
            if (m_active) check("gnt_idx", bus.gnt_idx, m_owner);
            check("timeout_err", bus.timeout_err, m_to);
        end
        @(posedge clk);
        model_update();
        #1;
        bus.sack  = 1'b0;
        bus.sresp = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!bus.busy && n < 10) begin
            tick();
            n++;
        end
        check(tag, bus.busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        int n;
        int div;
        rst       = 1'b1;
        bus.req   = '0;
        bus.cmd   = '0;
        bus.sack  = 1'b0;
        bus.sresp = 1'b0;
        #1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gnt_idx", bus.gnt_idx, 0);
        check("rst_timeout", bus.timeout_err, 0);

        // All four request writes: round robin from master 0, sack two cycles after each grant.
        bus.req = 4'b1111;
        bus.cmd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_busy("rr_wait");
            check("rr_idx", bus.gnt_idx, seq[i]);
            check("rr_gnt", bus.gnt, 32'd1 << seq[i]);
            tick();
            tick();
            bus.sack = 1'b1;
            tick();
            check("rr_gap", bus.busy, 0);
        end

        // Read to master 2; stray sack in IDLE and stray sresp in WAIT_ACK are ignored.
        bus.req  = 4'b0100;
        bus.cmd  = 4'b0000;
        bus.sack = 1'b1;
        tick();
        check("rd_gnt", bus.gnt, 4'b0100);
        tick();
        bus.sresp = 1'b1;
        tick();
        bus.sack = 1'b1;
        tick();
        check("rd_wresp", bus.busy, 1);
        tick();
        tick();
        bus.sresp = 1'b1;
        tick();
        check("rd_rel", bus.gnt, 0);

        // Owner drops req mid-transaction; then wrap from pointer 1 to master 0.
        bus.req = 4'b0010;
        bus.cmd = 4'b0010;
        tick();
        check("own_gnt", bus.gnt, 4'b0010);
        bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("own_hold", bus.gnt, 4'b0010);
        end
        bus.sack = 1'b1;
        tick();
        check("own_rel", bus.gnt, 0);
        bus.req = 4'b0011;
        bus.cmd = 4'b0011;
        tick();
        check("wrap_idx", bus.gnt_idx, 0);
        check("wrap_gnt", bus.gnt, 4'b0001);
        bus.req  = 4'b0000;
        bus.sack = 1'b1;
        tick();

        // Read finished by sack and sresp together.
        bus.req = 4'b0100;
        bus.cmd = 4'b0000;
        tick();
        check("both_gnt", bus.gnt, 4'b0100);
        bus.req   = 4'b0000;
        bus.sack  = 1'b1;
        bus.sresp = 1'b1;
        tick();
        check("both_idle", bus.busy, 0);
        check("both_gnt0", bus.gnt, 0);

        // Unanswered write to master 0 while master 1 waits.
        bus.req = 4'b0001;
        bus.cmd = 4'b0011;
        tick();
        check("wd_gnt", bus.gnt, 4'b0001);
        bus.req = 4'b0010;
`ifdef XBAR_ARB_TIMEOUT_EN
        n = 0;
        while (!bus.timeout_err && n < 20) begin
            tick();
            n++;
        end
        check("wd_latency", n, TO);
        check("wd_gnt0", bus.gnt, 0);
        tick();
        check("wd_next", bus.gnt, 4'b0010);
`else
        for (int i = 0; i < 20; i++) tick();
        check("wd_still_busy", bus.busy, 1);
        check("wd_no_err", bus.timeout_err, 0);
        bus.sack = 1'b1;
        tick();
        tick();
        check("wd_next", bus.gnt, 4'b0010);
`endif
        bus.req  = 4'b0000;
        bus.sack = 1'b1;
        tick();

        // Reset during WAIT_RESP of master 3, then master 3 again.
        bus.req = 4'b1000;
        bus.cmd = 4'b0000;
        tick();
        check("rr3_gnt", bus.gnt, 4'b1000);
        bus.sack = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mrst_gnt", bus.gnt, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_idx", bus.gnt_idx, 0);
        check("mrst_to", bus.timeout_err, 0);
        rst = 1'b0;
        tick();
        check("mrst_regrant", bus.gnt, 4'b1000);
        bus.sack  = 1'b1;
        bus.sresp = 1'b1;
        tick();

        // Random traffic with varying acknowledge density.
        for (int b = 0; b < 3; b++) begin
            div = (b == 0) ? 2 : ((b == 1) ? 4 : 12);
            for (int i = 0; i < 600; i++) begin
                rst       = ($urandom_range(0, 199) == 0);
                bus.req   = 4'($urandom);
                bus.cmd   = 4'($urandom);
                bus.sack  = ($urandom_range(0, div - 1) == 0);
                bus.sresp = ($urandom_range(0, div - 1) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
